// File: rtl/spi_pkg.sv
// Shared definitions for the mode-3 SPI master:
// FSM state encoding, SPI idle levels and default frame width.
package spi_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_e;

   localparam logic SCK_IDLE    = 1'b1;
   localparam logic CS_IDLE_LVL = 1'b1;
   localparam int   DATA_W_DEF  = 16;
   // Width of the SETUP/HOLD/GAP phase timer.
   localparam int   TMR_W       = 8;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider. sck_o idles high while en_i=0.
// Ports: clk_i, rst_ni, en_i; sck_o, sck_fall_o, sck_rise_o.
module spi_sck_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sck_o,
   output logic sck_fall_o,
   output logic sck_rise_o
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sck_q, sck_d;
   logic             tick;

   assign tick = en_i && (div_q == DIV_W'(CLK_DIV - 1));

   // Strobes mark the clk edge on which sck_q changes.
   assign sck_fall_o = tick && sck_q;
   assign sck_rise_o = tick && !sck_q;
   assign sck_o      = sck_q;

   always_comb begin
      div_d = div_q;
      sck_d = sck_q;
      if (!en_i) begin
         div_d = '0;
         sck_d = SCK_IDLE;
      end else if (tick) begin
         div_d = '0;
         sck_d = ~sck_q;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         sck_q <= SCK_IDLE;
      end else begin
         div_q <= div_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 3, MSB first, one full-duplex frame per start.
// Ports: clk, rst_n, start, data_in -> data_out, busy, done; SPI pins spi_*.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int CNT_W    = 5,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              spi_sck,
   output logic              spi_cs,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [CNT_W-1:0]  bit_q, bit_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cs_q, cs_d;
   logic              mosi_q, mosi_d;
   logic              sck_fall, sck_rise;

   spi_sck_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sck (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (state_q == S_SHIFT),
      .sck_o     (spi_sck),
      .sck_fall_o(sck_fall),
      .sck_rise_o(sck_rise)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      bit_d   = bit_q;
      tmr_d   = tmr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      unique case (state_q)
         S_IDLE: begin
            bit_d = '0;
            tmr_d = '0;
            if (start) begin
               tx_d    = data_in;
               rx_d    = '0;
               busy_d  = 1'b1;
               cs_d    = ~CS_IDLE_LVL;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
               tmr_d   = '0;
               state_d = S_SHIFT;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (sck_fall) begin
               mosi_d = tx_q[DATA_W-1];
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
            if (sck_rise) begin
               rx_d  = {rx_q[DATA_W-2:0], spi_miso};
               bit_d = bit_q + 1'b1;
               // Leaving SHIFT disables the divider, so sck stays high.
               if (bit_q == CNT_W'(DATA_W - 1)) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
               tmr_d   = '0;
               cs_d    = CS_IDLE_LVL;
               mosi_d  = 1'b0;
               dout_d  = rx_q;
               done_d  = 1'b1;
               state_d = S_GAP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_GAP: begin
            if (tmr_q == TMR_W'(CS_IDLE - 1)) begin
               tmr_d   = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         bit_q   <= '0;
         tmr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= CS_IDLE_LVL;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         bit_q   <= bit_d;
         tmr_q   <= tmr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
      end
   end

   assign data_out = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_cs   = cs_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback and mode-3 slave model,
// expected words queued at start and compared on each done pulse.
module tb_spi_master;

   localparam int DATA_W   = 16;
   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_IDLE  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [DATA_W-1:0] data_out;
   logic              busy, done;
   logic              spi_sck, spi_cs, spi_mosi, spi_miso;

   logic              use_slv = 1'b0;
   logic              slv_miso = 1'b0;
   logic [DATA_W-1:0] slv_tx = '0;
   logic [DATA_W-1:0] slv_rx = '0;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int cs_falls = 0;
   int sck_falls = 0;
   int cs_err = 0;

   logic [DATA_W-1:0] sb_q[$];

   always #5 clk = ~clk;

   assign spi_miso = use_slv ? slv_miso : spi_mosi;

   spi_master #(
      .DATA_W  (DATA_W),
      .CNT_W   (5),
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_IDLE (CS_IDLE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .data_in (data_in),
      .data_out(data_out),
      .busy    (busy),
      .done    (done),
      .spi_sck (spi_sck),
      .spi_cs  (spi_cs),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Mode-3 slave: drive on SCK fall, sample on SCK rise.
   always @(negedge spi_sck) begin
      sck_falls <= sck_falls + 1;
      if (spi_cs) cs_err <= cs_err + 1;
      if (!spi_cs) begin
         slv_miso <= slv_tx[DATA_W-1];
         slv_tx   <= {slv_tx[DATA_W-2:0], 1'b0};
      end
   end

   always @(posedge spi_sck) begin
      if (!spi_cs) slv_rx <= {slv_rx[DATA_W-2:0], spi_mosi};
   end

   always @(negedge spi_cs) begin
      if (rst_n) cs_falls <= cs_falls + 1;
   end

   // Scoreboard: every done pulse retires one expected word.
   always @(negedge clk) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         if (sb_q.size() == 0) chk("sb_empty", 0, 1);
         else chk("data_out", data_out, sb_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_cnt();
      done_cnt  = 0;
      cs_falls  = 0;
      sck_falls = 0;
      cs_err    = 0;
   endtask

   task automatic send(input logic [DATA_W-1:0] w,
                       input logic [DATA_W-1:0] exp);
      data_in = w;
      start   = 1'b1;
      sb_q.push_back(exp);
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(tag, 32'(ok), 1);
   endtask

   task automatic wait_falls(input int n, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (sck_falls >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(tag, 32'(ok), 1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_cs, last_cs, done_cyc, fall_cyc, gap;

      #2 rst_n = 1'b0;
      step();
      step();
      chk("rst_data_out", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sck", spi_sck, 1);
      chk("rst_cs", spi_cs, 1);
      chk("rst_mosi", spi_mosi, 0);
      rst_n = 1'b1;
      step();

      // 1: loopback
      zero_cnt();
      send(16'hA55A, 16'hA55A);
      wait_done("t1_done");
      repeat (5) step();
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_sck_falls", sck_falls, 16);
      chk("t1_cs_falls", cs_falls, 1);
      chk("t1_cs_low", cs_err, 0);

      // 2: slave model
      wait_idle("t2_idle");
      use_slv = 1'b1;
      slv_tx  = 16'h1234;
      send(16'hBEEF, 16'h1234);
      wait_done("t2_done");
      repeat (2) step();
      chk("t2_slv_rx", slv_rx, 16'hBEEF);
      use_slv = 1'b0;

      // 3: timing; start driven in cycle 0, accepted at its end
      wait_idle("t3_idle");
      first_cs = -1;
      last_cs  = -1;
      done_cyc = -1;
      fall_cyc = -1;
      send(16'h3C96, 16'h3C96);
      for (int c = 1; c <= 140; c++) begin
         if (!spi_cs) begin
            if (first_cs < 0) first_cs = c;
            last_cs = c;
         end
         if (!spi_sck && fall_cyc < 0) fall_cyc = c;
         if (done && done_cyc < 0) done_cyc = c;
         if (c == 1) chk("t3_busy_c1", busy, 1);
         if (c == 134) chk("t3_busy_c134", busy, 1);
         if (c == 135) chk("t3_busy_c135", busy, 0);
         step();
      end
      chk("t3_first_cs", first_cs, 1);
      chk("t3_last_cs", last_cs, 132);
      chk("t3_done_cyc", done_cyc, 133);
      // divider hits terminal count in cycle 3+CLK_DIV-1; sck drops after it
      chk("t3_first_fall", fall_cyc, 3 + CLK_DIV);

      // 4: ignored start requests
      wait_idle("t4_idle");
      zero_cnt();
      send(16'h5A0F, 16'h5A0F);
      wait_falls(6, "t4_bit5");
      data_in = 16'hFFFF;
      start   = 1'b1;
      step();
      start = 1'b0;
      wait_done("t4_done");
      data_in = 16'h0000;
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_cs_falls", cs_falls, 1);
      chk("t4_data_out", data_out, 16'h5A0F);
      chk("t4_busy", busy, 0);

      // 5: reset mid-frame
      zero_cnt();
      data_in = 16'hC3A5;
      start   = 1'b1;
      step();
      start = 1'b0;
      wait_falls(8, "t5_bit7");
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_sck", spi_sck, 1);
      chk("t5_cs", spi_cs, 1);
      chk("t5_mosi", spi_mosi, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      step();
      step();
      chk("t5_no_done", done_cnt, 0);
      chk("t5_data_out", data_out, 0);
      rst_n = 1'b1;
      step();
      send(16'h00FF, 16'h00FF);
      wait_done("t5_done2");
      repeat (5) step();
      chk("t5_done_cnt", done_cnt, 1);

      // 6: start held high, back-to-back frames
      wait_idle("t6_idle");
      zero_cnt();
      data_in = 16'h8001;
      start   = 1'b1;
      sb_q.push_back(16'h8001);
      step();
      data_in = 16'h7FFE;
      sb_q.push_back(16'h7FFE);
      wait_done("t6_done1");
      gap = 0;
      for (int i = 0; i < 50; i++) begin
         if (!spi_cs) break;
         gap++;
         step();
      end
      chk("t6_cs_gap", gap, CS_IDLE + 1);
      start = 1'b0;
      wait_done("t6_done2");
      repeat (5) step();
      chk("t6_done_cnt", done_cnt, 2);
      chk("t6_cs_falls", cs_falls, 2);
      chk("t6_sb_left", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
